// File: rtl/la_acq.sv
// Logic-analyzer acquisition controller: gates the trigger-stage stream through a
// pre-trigger / armed / post-trigger sequence and terminates the capture with TLAST.
module la_acq #(
    parameter int DN = 2,
    parameter int DW = 8,
    parameter int CW = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ctl_rst,
    input  logic              ctl_acq,
    input  logic              ctl_stp,
    input  logic [CW-1:0]     cfg_pre,
    input  logic [CW-1:0]     cfg_pst,
    input  logic              trg_in,
    input  logic [DN*DW-1:0]  sti_tdata,
    input  logic [DN-1:0]     sti_tkeep,
    input  logic              sti_tvalid,
    output logic              sti_tready,
    output logic [DN*DW-1:0]  sto_tdata,
    output logic [DN-1:0]     sto_tkeep,
    output logic              sto_tlast,
    output logic              sto_tvalid,
    input  logic              sto_tready,
    output logic              sts_acq,
    output logic              sts_trg,
    output logic [CW-1:0]     sts_pre,
    output logic [CW-1:0]     sts_pst
);

    typedef enum logic [1:0] {IDLE, PRE, ARM, POST} state_t;

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state, state_nxt;
    logic          trg_nxt;
    logic [CW-1:0] pre_nxt, pst_nxt;
    logic [CW-1:0] pre_inc;
    logic          active, xfer, pre_done, pst_done, pst_zero;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    assign active     = (state != IDLE);
    assign sto_tdata  = sti_tdata;
    assign sto_tkeep  = sti_tkeep;
    assign sto_tvalid = sti_tvalid & active;
    assign sti_tready = active ? sto_tready : 1'b1;
    assign xfer       = sti_tvalid & sti_tready;
    assign sts_acq    = active;

    assign pre_inc  = sat_inc(sts_pre);
    assign pre_done = (pre_inc == cfg_pre);
    assign pst_done = ((sts_pst + ONE) == cfg_pst);
    assign pst_zero = (cfg_pst == '0);

    // TLAST is held with the beat while stalled so it stays stable with tdata
    assign sto_tlast = sti_tvalid &
                       (((state == ARM) & trg_in & pst_zero) |
                        ((state == POST) & pst_done));

    always_comb begin
        state_nxt = state;
        pre_nxt   = sts_pre;
        pst_nxt   = sts_pst;
        trg_nxt   = sts_trg;
        if (ctl_rst) begin
            state_nxt = IDLE;
            pre_nxt   = '0;
            pst_nxt   = '0;
            trg_nxt   = 1'b0;
        end else begin
            if (xfer) begin
                case (state)
                    PRE: begin
                        pre_nxt = pre_inc;
                        if (pre_done) state_nxt = ARM;
                    end
                    ARM: begin
                        if (trg_in) begin
                            trg_nxt   = 1'b1;
                            state_nxt = pst_zero ? IDLE : POST;
                        end else begin
                            pre_nxt = pre_inc;
                        end
                    end
                    POST: begin
                        pst_nxt = sts_pst + ONE;
                        if (pst_done) state_nxt = IDLE;
                    end
                    default: ;
                endcase
            end
            // A beat accepted alongside stop is still counted; only the state is overridden
            if (ctl_stp) begin
                state_nxt = IDLE;
            end else if (ctl_acq && !active) begin
                pre_nxt   = '0;
                pst_nxt   = '0;
                trg_nxt   = 1'b0;
                state_nxt = (cfg_pre != '0) ? PRE : ARM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            sts_pre <= '0;
            sts_pst <= '0;
            sts_trg <= 1'b0;
        end else begin
            state   <= state_nxt;
            sts_pre <= pre_nxt;
            sts_pst <= pst_nxt;
            sts_trg <= trg_nxt;
        end
    end

endmodule

// File: tb/tb_la_acq.sv
// Scoreboard bench for la_acq: the driver queues expected output beats, a negedge
// monitor pops and compares them; status registers are checked between phases.
module tb_la_acq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ctl_rst = 1'b0, ctl_acq = 1'b0, ctl_stp = 1'b0, ctl_acq_s = 1'b0;
    logic [31:0] cfg_pre = '0, cfg_pst = '0;
    logic        trg_in = 1'b0;
    logic [15:0] sti_tdata = '0;
    logic [1:0]  sti_tkeep = '0;
    logic        sti_tvalid = 1'b0;
    logic        sti_tready;
    logic [15:0] sto_tdata;
    logic [1:0]  sto_tkeep;
    logic        sto_tlast, sto_tvalid;
    logic        sto_tready = 1'b1;
    logic        sts_acq, sts_trg;
    logic [31:0] sts_pre, sts_pst;

    logic        sti_tready_s, sto_tlast_s, sto_tvalid_s, sts_acq_s, sts_trg_s;
    logic [15:0] sto_tdata_s;
    logic [1:0]  sto_tkeep_s;
    logic [3:0]  sts_pre_s, sts_pst_s;

    int n_vec = 0;
    int n_err = 0;
    bit rand_en = 1'b0;
    logic [18:0] sb_q[$];

    always #5 clk = ~clk;

    la_acq #(.DN(2), .DW(8), .CW(32)) dut (
        .clk(clk), .rstn(rstn), .ctl_rst(ctl_rst), .ctl_acq(ctl_acq), .ctl_stp(ctl_stp),
        .cfg_pre(cfg_pre), .cfg_pst(cfg_pst), .trg_in(trg_in),
        .sti_tdata(sti_tdata), .sti_tkeep(sti_tkeep), .sti_tvalid(sti_tvalid),
        .sti_tready(sti_tready), .sto_tdata(sto_tdata), .sto_tkeep(sto_tkeep),
        .sto_tlast(sto_tlast), .sto_tvalid(sto_tvalid), .sto_tready(sto_tready),
        .sts_acq(sts_acq), .sts_trg(sts_trg), .sts_pre(sts_pre), .sts_pst(sts_pst)
    );

    // Narrow-counter instance used only for the saturation case
    la_acq #(.DN(2), .DW(8), .CW(4)) dut_sat (
        .clk(clk), .rstn(rstn), .ctl_rst(ctl_rst), .ctl_acq(ctl_acq_s), .ctl_stp(1'b0),
        .cfg_pre(4'd0), .cfg_pst(4'd0), .trg_in(trg_in),
        .sti_tdata(sti_tdata), .sti_tkeep(sti_tkeep), .sti_tvalid(sti_tvalid),
        .sti_tready(sti_tready_s), .sto_tdata(sto_tdata_s), .sto_tkeep(sto_tkeep_s),
        .sto_tlast(sto_tlast_s), .sto_tvalid(sto_tvalid_s), .sto_tready(1'b1),
        .sts_acq(sts_acq_s), .sts_trg(sts_trg_s), .sts_pre(sts_pre_s), .sts_pst(sts_pst_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_sts(input string tag, input bit acq, input bit trg,
                             input int pre, input int pst);
        @(negedge clk);
        check({tag, ".sts_acq"}, 64'(sts_acq), 64'(acq));
        check({tag, ".sts_trg"}, 64'(sts_trg), 64'(trg));
        check({tag, ".sts_pre"}, 64'(sts_pre), 64'(pre));
        check({tag, ".sts_pst"}, 64'(sts_pst), 64'(pst));
    endtask

    task automatic pulse_acq();
        @(posedge clk); #1 ctl_acq = 1'b1;
        @(posedge clk); #1 ctl_acq = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input bit t,
                             input bit exp_out, input bit exp_last);
        bit hs;
        int n;
        @(posedge clk); #1;
        sti_tdata = d; sti_tkeep = k; trg_in = t; sti_tvalid = 1'b1;
        if (exp_out) sb_q.push_back({k, d, exp_last});
        hs = 1'b0;
        n = 0;
        while (!hs) begin
            @(negedge clk);
            hs = sti_tready;
            @(posedge clk); #1;
            n++;
            if (!hs && n > 200) begin
                check("handshake_timeout", 64'(0), 64'(1));
                break;
            end
        end
        sti_tvalid = 1'b0;
        trg_in = 1'b0;
    endtask

    // Ramp used by scenarios 1 and 4: trigger on beat 6, beats 0..9 pass, 9 is last
    task automatic ramp_scenario(input string tag);
        cfg_pre = 32'd4; cfg_pst = 32'd3;
        pulse_acq();
        for (int i = 0; i < 16; i++)
            send_beat({8'(i + 16), 8'(i)}, (i % 3 == 0) ? 2'b01 : 2'b11,
                      i == 6, i <= 9, i == 9);
        check_sts(tag, 1'b0, 1'b1, 6, 3);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_en) sto_tready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compare every delivered beat and check stability across stalls
    initial begin
        logic [18:0] exp_b;
        logic [18:0] held;
        bit stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (stalled) begin
                check("stall_valid_held", 64'(sto_tvalid), 64'(1));
                check("stall_beat_held", 64'({sto_tkeep, sto_tdata, sto_tlast}), 64'(held));
            end
            stalled = sto_tvalid && !sto_tready;
            held = {sto_tkeep, sto_tdata, sto_tlast};
            if (sto_tvalid && sto_tready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 64'({sto_tkeep, sto_tdata, sto_tlast}), 64'h7ffff);
                end else begin
                    exp_b = sb_q.pop_front();
                    check("out_beat", 64'({sto_tkeep, sto_tdata, sto_tlast}), 64'(exp_b));
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        check_sts("reset", 1'b0, 1'b0, 0, 0);
        check("reset.sti_tready", 64'(sti_tready), 64'(1));
        check("reset.sto_tvalid", 64'(sto_tvalid), 64'(0));
        @(posedge clk); #1 rstn = 1'b1;

        ramp_scenario("t1");

        // Triggers during PRE are ignored; trigger on beat 5 accepted
        pulse_acq();
        for (int i = 0; i < 10; i++)
            send_beat(16'(16'h0200 + i), 2'b11, (i == 1) || (i == 2) || (i == 5),
                      i <= 8, i == 8);
        check_sts("t2", 1'b0, 1'b1, 5, 3);

        // Zero pre/post: the first beat is both trigger and last
        cfg_pre = 32'd0; cfg_pst = 32'd0;
        pulse_acq();
        check_sts("t3.armed", 1'b1, 1'b0, 0, 0);
        send_beat(16'hA55A, 2'b10, 1'b1, 1'b1, 1'b1);
        check_sts("t3", 1'b0, 1'b1, 0, 0);

        rand_en = 1'b1;
        ramp_scenario("t4");
        rand_en = 1'b0;
        @(posedge clk); #2 sto_tready = 1'b1;

        // Stop in ARM after 10 beats, then acq+stp together in IDLE
        cfg_pre = 32'd0; cfg_pst = 32'd3;
        pulse_acq();
        for (int i = 0; i < 10; i++) send_beat(16'(16'h0500 + i), 2'b11, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1 ctl_stp = 1'b1;
        @(posedge clk); #1 ctl_stp = 1'b0;
        check_sts("t5.stop", 1'b0, 1'b0, 10, 0);
        send_beat(16'h0555, 2'b11, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1 ctl_stp = 1'b1; ctl_acq = 1'b1;
        @(posedge clk); #1 ctl_stp = 1'b0; ctl_acq = 1'b0;
        check_sts("t5.both", 1'b0, 1'b0, 10, 0);

        // Software reset in POST with sts_pst=2
        cfg_pre = 32'd0; cfg_pst = 32'd5;
        pulse_acq();
        send_beat(16'h0600, 2'b11, 1'b1, 1'b1, 1'b0);
        send_beat(16'h0601, 2'b11, 1'b0, 1'b1, 1'b0);
        send_beat(16'h0602, 2'b11, 1'b0, 1'b1, 1'b0);
        check_sts("t6.post", 1'b1, 1'b1, 0, 2);
        @(posedge clk); #1 ctl_rst = 1'b1;
        @(posedge clk); #1 ctl_rst = 1'b0;
        check_sts("t6.ctl_rst", 1'b0, 1'b0, 0, 0);

        // Hardware reset mid-stream
        pulse_acq();
        send_beat(16'h0700, 2'b11, 1'b0, 1'b1, 1'b0);
        send_beat(16'h0701, 2'b11, 1'b0, 1'b1, 1'b0);
        send_beat(16'h0702, 2'b11, 1'b1, 1'b1, 1'b0);
        send_beat(16'h0703, 2'b11, 1'b0, 1'b1, 1'b0);
        check_sts("t6.pre_rstn", 1'b1, 1'b1, 2, 1);
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        check_sts("t6.rstn", 1'b0, 1'b0, 0, 0);

        // Saturation of a 4-bit pre counter
        @(posedge clk); #1 ctl_acq_s = 1'b1;
        @(posedge clk); #1 ctl_acq_s = 1'b0;
        for (int i = 0; i < 20; i++) send_beat(16'(16'h0800 + i), 2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("sat.sts_pre", 64'(sts_pre_s), 64'(15));
        check("sat.sts_acq", 64'(sts_acq_s), 64'(1));
        check("sat.sts_trg", 64'(sts_trg_s), 64'(0));

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
